// File: rtl/window_extrema_tracker.sv
// Windowed min/max tracker: running extrema plus per-window latched
// results with sample positions and a completed-window counter.
module window_extrema_tracker #(
  parameter int unsigned DATA_W  = 9,
  parameter int unsigned WIN_LEN = 32'h5FA000,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned WCNT_W  = 16
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              wren,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr,
  output logic [DATA_W-1:0] run_min,
  output logic [DATA_W-1:0] run_max,
  output logic              run_valid,
  output logic [DATA_W-1:0] min_out,
  output logic [DATA_W-1:0] max_out,
  output logic [CNT_W-1:0]  min_pos,
  output logic [CNT_W-1:0]  max_pos,
  output logic              win_done,
  output logic [WCNT_W-1:0] win_count
);

  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(WIN_LEN - 1);
  localparam logic [DATA_W-1:0] ONES     = '1;

  logic [CNT_W-1:0]  idx;
  logic [CNT_W-1:0]  run_min_pos;
  logic [CNT_W-1:0]  run_max_pos;

  logic              take_min;
  logic              take_max;
  logic              last;
  logic [DATA_W-1:0] nxt_min;
  logic [DATA_W-1:0] nxt_max;
  logic [CNT_W-1:0]  nxt_min_pos;
  logic [CNT_W-1:0]  nxt_max_pos;

  // First sample of a window seeds both extrema regardless of value.
  always_comb begin
    take_min    = !run_valid || (data_in < run_min);
    take_max    = !run_valid || (data_in > run_max);
    nxt_min     = take_min ? data_in : run_min;
    nxt_max     = take_max ? data_in : run_max;
    nxt_min_pos = take_min ? idx : run_min_pos;
    nxt_max_pos = take_max ? idx : run_max_pos;
    last        = (idx == LAST_IDX);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      run_valid   <= 1'b0;
      run_min     <= ONES;
      run_max     <= '0;
      run_min_pos <= '0;
      run_max_pos <= '0;
      min_out     <= ONES;
      max_out     <= '0;
      min_pos     <= '0;
      max_pos     <= '0;
      win_done    <= 1'b0;
      win_count   <= '0;
    end else begin
      win_done <= 1'b0;
      if (clr) begin
        idx         <= '0;
        run_valid   <= 1'b0;
        run_min     <= ONES;
        run_max     <= '0;
        run_min_pos <= '0;
        run_max_pos <= '0;
      end else if (wren) begin
        if (last) begin
          min_out     <= nxt_min;
          max_out     <= nxt_max;
          min_pos     <= nxt_min_pos;
          max_pos     <= nxt_max_pos;
          win_done    <= 1'b1;
          win_count   <= win_count + 1'b1;
          idx         <= '0;
          run_valid   <= 1'b0;
          run_min     <= ONES;
          run_max     <= '0;
          run_min_pos <= '0;
          run_max_pos <= '0;
        end else begin
          run_min     <= nxt_min;
          run_max     <= nxt_max;
          run_min_pos <= nxt_min_pos;
          run_max_pos <= nxt_max_pos;
          run_valid   <= 1'b1;
          idx         <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_window_extrema_tracker.sv
// Directed bench for window_extrema_tracker with a 4-sample window.
// Per-cycle vectors carry the full expected output state.
module tb_window_extrema_tracker;

  localparam int DW = 9;
  localparam int CW = 32;
  localparam int WW = 16;

  logic          clock;
  logic          rst_n;
  logic          wren;
  logic [DW-1:0] data_in;
  logic          clr;
  logic [DW-1:0] run_min;
  logic [DW-1:0] run_max;
  logic          run_valid;
  logic [DW-1:0] min_out;
  logic [DW-1:0] max_out;
  logic [CW-1:0] min_pos;
  logic [CW-1:0] max_pos;
  logic          win_done;
  logic [WW-1:0] win_count;

  window_extrema_tracker #(
    .DATA_W (DW),
    .WIN_LEN(4),
    .CNT_W  (CW),
    .WCNT_W (WW)
  ) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .wren     (wren),
    .data_in  (data_in),
    .clr      (clr),
    .run_min  (run_min),
    .run_max  (run_max),
    .run_valid(run_valid),
    .min_out  (min_out),
    .max_out  (max_out),
    .min_pos  (min_pos),
    .max_pos  (max_pos),
    .win_done (win_done),
    .win_count(win_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic          w;
    logic          c;
    logic [DW-1:0] d;
    logic [DW-1:0] rmin;
    logic [DW-1:0] rmax;
    logic          rv;
    logic [DW-1:0] mn;
    logic [DW-1:0] mx;
    logic [CW-1:0] mnp;
    logic [CW-1:0] mxp;
    logic          done;
    logic [WW-1:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_tests;
  int   n_fail;

  function automatic vec_t mk(int w, int c, int d,
                              int rmin, int rmax, int rv,
                              int mn, int mx, int mnp, int mxp,
                              int done, int cnt);
    vec_t r;
    r.w    = w[0];
    r.c    = c[0];
    r.d    = DW'(d);
    r.rmin = DW'(rmin);
    r.rmax = DW'(rmax);
    r.rv   = rv[0];
    r.mn   = DW'(mn);
    r.mx   = DW'(mx);
    r.mnp  = CW'(mnp);
    r.mxp  = CW'(mxp);
    r.done = done[0];
    r.cnt  = WW'(cnt);
    return r;
  endfunction

  task automatic check(string name, vec_t e);
    n_tests++;
    if ({run_min, run_max, run_valid, min_out, max_out,
         min_pos, max_pos, win_done, win_count} !==
        {e.rmin, e.rmax, e.rv, e.mn, e.mx,
         e.mnp, e.mxp, e.done, e.cnt}) begin
      n_fail++;
      $display("FAIL %s: got run=%h/%h/%b lat=%h/%h pos=%0d/%0d done=%b cnt=%0d exp run=%h/%h/%b lat=%h/%h pos=%0d/%0d done=%b cnt=%0d",
               name, run_min, run_max, run_valid, min_out, max_out,
               min_pos, max_pos, win_done, win_count,
               e.rmin, e.rmax, e.rv, e.mn, e.mx,
               e.mnp, e.mxp, e.done, e.cnt);
    end
  endtask

  task automatic step(string name, vec_t v);
    @(negedge clock);
    wren    = v.w;
    clr     = v.c;
    data_in = v.d;
    @(posedge clock);
    #1;
    check(name, v);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    wren    = 1'b0;
    clr     = 1'b0;
    data_in = '0;

    // 5,3,7,3: tie on last 3 keeps pos 1
    vecs.push_back(mk(1,0,5,   5,5,1,     'h1FF,0,0,0, 0,0));
    vecs.push_back(mk(1,0,3,   3,5,1,     'h1FF,0,0,0, 0,0));
    vecs.push_back(mk(1,0,7,   3,7,1,     'h1FF,0,0,0, 0,0));
    vecs.push_back(mk(1,0,3,   'h1FF,0,0, 3,7,1,2,     1,1));
    // 8,_,2,_,9,4 with idle zeros ignored
    vecs.push_back(mk(1,0,8,   8,8,1,     3,7,1,2,     0,1));
    vecs.push_back(mk(0,0,0,   8,8,1,     3,7,1,2,     0,1));
    vecs.push_back(mk(1,0,2,   2,8,1,     3,7,1,2,     0,1));
    vecs.push_back(mk(0,0,0,   2,8,1,     3,7,1,2,     0,1));
    vecs.push_back(mk(1,0,9,   2,9,1,     3,7,1,2,     0,1));
    vecs.push_back(mk(1,0,4,   'h1FF,0,0, 2,9,1,2,     1,2));
    // back-to-back windows at data extremes
    vecs.push_back(mk(1,0,'h1FF, 'h1FF,'h1FF,1, 2,9,1,2, 0,2));
    vecs.push_back(mk(1,0,'h1FF, 'h1FF,'h1FF,1, 2,9,1,2, 0,2));
    vecs.push_back(mk(1,0,0,   0,'h1FF,1, 2,9,1,2,     0,2));
    vecs.push_back(mk(1,0,0,   'h1FF,0,0, 0,'h1FF,2,0, 1,3));
    vecs.push_back(mk(1,0,1,   1,1,1,     0,'h1FF,2,0, 0,3));
    vecs.push_back(mk(1,0,1,   1,1,1,     0,'h1FF,2,0, 0,3));
    vecs.push_back(mk(1,0,1,   1,1,1,     0,'h1FF,2,0, 0,3));
    vecs.push_back(mk(1,0,1,   'h1FF,0,0, 1,1,0,0,     1,4));
    // clr on 3rd sample, then clr on the would-be last sample
    vecs.push_back(mk(1,0,10,  10,10,1,   1,1,0,0,     0,4));
    vecs.push_back(mk(1,0,20,  10,20,1,   1,1,0,0,     0,4));
    vecs.push_back(mk(1,1,30,  'h1FF,0,0, 1,1,0,0,     0,4));
    vecs.push_back(mk(1,0,10,  10,10,1,   1,1,0,0,     0,4));
    vecs.push_back(mk(1,0,20,  10,20,1,   1,1,0,0,     0,4));
    vecs.push_back(mk(1,0,30,  10,30,1,   1,1,0,0,     0,4));
    vecs.push_back(mk(1,1,40,  'h1FF,0,0, 1,1,0,0,     0,4));
    vecs.push_back(mk(1,0,50,  50,50,1,   1,1,0,0,     0,4));
    vecs.push_back(mk(1,0,40,  40,50,1,   1,1,0,0,     0,4));
    vecs.push_back(mk(1,0,60,  40,60,1,   1,1,0,0,     0,4));
    vecs.push_back(mk(1,0,45,  'h1FF,0,0, 40,60,1,2,   1,5));
    // live running extrema
    vecs.push_back(mk(1,0,6,   6,6,1,     40,60,1,2,   0,5));
    vecs.push_back(mk(1,0,2,   2,6,1,     40,60,1,2,   0,5));
    vecs.push_back(mk(1,0,9,   2,9,1,     40,60,1,2,   0,5));

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset", mk(0,0,0, 'h1FF,0,0, 'h1FF,0,0,0, 0,0));
    rst_n = 1'b1;

    foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i]);

    // async reset mid-window, between edges
    @(negedge clock);
    wren = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("async_reset", mk(0,0,0, 'h1FF,0,0, 'h1FF,0,0,0, 0,0));
    @(negedge clock);
    rst_n = 1'b1;

    // partial window lost: four fresh samples needed to close
    step("post_rst0", mk(1,0,7, 7,7,1,   'h1FF,0,0,0, 0,0));
    step("post_rst1", mk(1,0,7, 7,7,1,   'h1FF,0,0,0, 0,0));
    step("post_rst2", mk(1,0,8, 7,8,1,   'h1FF,0,0,0, 0,0));
    step("post_rst3", mk(1,0,7, 'h1FF,0,0, 7,8,0,2, 1,1));
    step("done_drop", mk(0,0,0, 'h1FF,0,0, 7,8,0,2, 0,1));
    step("clr_idle",  mk(0,1,0, 'h1FF,0,0, 7,8,0,2, 0,1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
